// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: 1-cycle multiply, 32-cycle restoring divide.
// Holds the pipeline through stallreq until the one-cycle ready pulse; cancel aborts the operation.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            cancel,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            stallreq
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [2:0]      op_q, op_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand preparation in IDLE
  logic            signed_op, src1_neg, src2_neg, ovf;
  logic [XLEN-1:0] abs1, abs2;

  assign signed_op = (op == 3'd4) || (op == 3'd6);
  assign src1_neg  = signed_op & src1[XLEN-1];
  assign src2_neg  = signed_op & src2[XLEN-1];
  assign abs1      = src1_neg ? (~src1 + 1'b1) : src1;
  assign abs2      = src2_neg ? (~src2 + 1'b1) : src2;
  assign ovf       = signed_op && (src1 == INT_MIN) && (&src2);

  // One restoring-division step; the quotient shifts into the dividend register
  logic [XLEN:0]   rem_shift, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt, dvd_nxt, quot_fix, rem_fix;

  assign rem_shift = {rem_q, dvd_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~diff[XLEN];
  assign rem_nxt   = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign dvd_nxt   = {dvd_q[XLEN-2:0], q_bit};
  assign quot_fix  = negq_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
  assign rem_fix   = negr_q ? (~rem_nxt + 1'b1) : rem_nxt;

  // Multiply on latched operands; low 2*XLEN bits of the extended product are exact
  logic              mul_a_sx, mul_b_sx;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_sx = ((op_q == 3'd1) || (op_q == 3'd2)) & dvd_q[XLEN-1];
  assign mul_b_sx = (op_q == 3'd1) & dvs_q[XLEN-1];
  assign mul_a    = {{XLEN{mul_a_sx}}, dvd_q};
  assign mul_b    = {{XLEN{mul_b_sx}}, dvs_q};
  assign prod     = mul_a * mul_b;
  assign mul_res  = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d = op;
            if (!op[2]) begin
              dvd_d   = src1;
              dvs_d   = src2;
              state_d = S_MUL;
            end else if (src2 == '0) begin
              result_d = op[1] ? src1 : '1;
              state_d  = S_DONE;
            end else if (ovf) begin
              result_d = op[1] ? '0 : INT_MIN;
              state_d  = S_DONE;
            end else begin
              dvd_d   = abs1;
              dvs_d   = abs2;
              negq_d  = src1_neg ^ src2_neg;
              negr_d  = src1_neg;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          result_d = mul_res;
          state_d  = S_DONE;
        end
        S_DIV: begin
          dvd_d = dvd_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = op_q[1] ? rem_fix : quot_fix;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // stallreq is gated by rst so ctrl never sees a stall while the unit is held in reset
  always_comb begin
    ready    = (state_q == S_DONE) & ~cancel;
    stallreq = rst & start & ~ready & ~cancel;
    result   = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        cancel;
  logic [31:0] result;
  logic        ready;
  logic        stallreq;

  int vectors = 0;
  int miscompares = 0;

  ex_muldiv #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .result(result), .ready(ready), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p = '0;
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 2;
    if (b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called just after a rising edge; returns just after the edge following ready (an IDLE cycle).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, stall_cnt;
    logic got;
    exp = ref_res(o, a, b);
    lat = ref_lat(o, a, b);
    start = 1'b1; op = o; src1 = a; src2 = b; cancel = 1'b0;
    stall_cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (ready) begin
        check("latency", 64'(c), 64'(lat));
        check("result", 64'(result), 64'(exp));
        check("stall_at_ready", 64'(stallreq), 64'(0));
        got = 1'b1;
      end else if (stallreq) begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      if (!got) begin
        src1 = $urandom;
        src2 = $urandom;
      end
    end
    check("ready_seen", 64'(got), 64'(1));
    check("stall_cycles", 64'(stall_cnt), 64'(lat));
  endtask

  task automatic go_idle();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          nready;
    rst = 1'b0; start = 1'b1; op = 3'd4; src1 = 32'd9; src2 = 32'd3; cancel = 1'b0;
    #3;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_stallreq", 64'(stallreq), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_ready", 64'(ready), 64'(0));
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      logic [2:0] mo [4];
      mo = '{3'd0, 3'd1, 3'd3, 3'd2};
      run_op(mo[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_all_ones", 64'(result), 64'(ref_res(mo[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF)));
    end
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", 64'(result), 64'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2", 64'(result), 64'hFFFF_FFFF);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2);
    check("divu_m7_2", 64'(result), 64'h7FFF_FFFC);
    for (int i = 4; i < 8; i++) run_op(3'(i), 32'h1234_5678, 32'h0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divu_ovf_operands", 64'(result), 64'h0);
    go_idle();

    // Cancel at cycle 10 of a DIV
    start = 1'b1; op = 3'd4; src1 = 32'd1000; src2 = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_stallreq", 64'(stallreq), 64'(0));
    check("cancel_ready", 64'(ready), 64'(0));
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    nready = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) nready++;
    end
    check("cancel_no_ready", 64'(nready), 64'(0));
    @(posedge clk); #1;
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000);
    check("mulhu_after_cancel", 64'(result), 64'h1);
    go_idle();

    // Asynchronous reset in the middle of a DIV
    start = 1'b1; op = 3'd4; src1 = 32'd5000; src2 = 32'd3;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_ready", 64'(ready), 64'(0));
    check("arst_result", 64'(result), 64'(0));
    check("arst_stallreq", 64'(stallreq), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    run_op(3'd5, 32'd100, 32'd7);
    check("divu_100_7", 64'(result), 64'd14);
    run_op(3'd7, 32'd100, 32'd7);
    check("remu_100_7", 64'(result), 64'd2);
    go_idle();

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(ro, ra, rb);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit inside the EX stage.
- It consumes the operands and operation latched by the ID/EX pipeline register.
- It raises a stall request to ctrl while a multi-cycle operation is in flight, so ID/EX and earlier stages hold their contents.
- The result goes to the EX result mux in the cycle `ready` is high; the EX/MEM register then captures it.

Parameters:
- XLEN, 32, operand and result width.
- DIV_CYCLES, 32, number of restoring-division iterations; must equal XLEN.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  EX decode has an M-extension op in EX; held high with stable operands while stallreq=1.
- op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1  in  XLEN  rs1 value (ex_reg1).
- src2  in  XLEN  rs2 value (ex_reg2).
- cancel  in  1  flush of the EX instruction; aborts any operation.
- result  out  XLEN  operation result; valid only when ready=1.
- ready  out  1  one-cycle pulse: result valid, instruction may leave EX.
- stallreq  out  1  to ctrl; stall request from EX.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, result=0, ready=0, counter=0, all datapath registers 0. stallreq is forced 0 while rst=0.
- stallreq is combinational: start & ~ready & ~cancel.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1 & cancel=0:
  - op<4 -> MUL.
  - op>=4 and src2==0 -> DONE with divide-by-zero result.
  - op>=4, signed op (DIV/REM), src1=0x80000000 and src2=0xFFFFFFFF -> DONE with overflow result.
  - Otherwise -> DIV. Latch |src1|, |src2| (absolute values for signed ops, raw for unsigned), the quotient-negate flag (signs differ), the remainder-negate flag (src1 negative), op, counter=0, partial remainder=0.
- MUL: one cycle. Form a 2*XLEN product with operands sign- or zero-extended per op:
  - MULH: s×s.
  - MULHSU: s×u.
  - MULHU and MUL: u×u.
  - Register result as low half (MUL) or high half (others) -> DONE. Latency: start seen at cycle 0, ready=1 at cycle 2.
- DIV: restoring division, one quotient bit per cycle, MSB first.
  - rem' = {rem, dividend_msb}.
  - If rem' >= divisor: subtract and shift in 1, else shift in 0.
  - The counter increments each cycle. At counter==DIV_CYCLES-1, apply sign correction (two's-complement negate where flagged), select quotient (DIV/DIVU) or remainder (REM/REMU) into result, then go to DONE.
  - ready=1 at cycle DIV_CYCLES+1 = 33.
- Divide-by-zero results: quotient=0xFFFFFFFF for both DIV and DIVU; remainder=src1. ready=1 at cycle 1.
- Overflow result: DIV gives 0x80000000; REM gives 0. ready=1 at cycle 1.
- DONE: ready=1 for exactly one cycle, result held -> IDLE unconditionally.
  - stallreq=0 in this cycle, so the pipeline advances.
  - The next cycle's start belongs to the next instruction, so back-to-back M ops restart from IDLE with no extra bubble beyond the IDLE cycle.
- cancel=1 in any state: next state IDLE, ready=0, counter=0. stallreq is 0 that same cycle. Cancel takes priority over start.
- Operand changes while in MUL/DIV are ignored; only values latched in IDLE are used.
- Reset asserted mid-operation: immediate return to IDLE, ready=0, no partial result emitted.
- ready is never high in IDLE, MUL or DIV. result is not modified outside the cycle entering DONE.

Test Plan:
- MUL src1=0xFFFFFFFF, src2=0xFFFFFFFF: MUL -> 0x00000001; MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF. Each with stallreq=1 for 2 cycles and ready at cycle 2.
- DIV src1=-7 (0xFFFFFFF9), src2=2: DIV -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU -> 0x7FFFFFFC. ready at cycle 33; stallreq high cycles 0–32.
- Divide by zero, src1=0x12345678, src2=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> 0x12345678. ready at cycle 1.
- Overflow, src1=0x80000000, src2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0, ready at cycle 1. DIVU of the same operands takes the full 33-cycle path and gives 0.
- cancel pulsed at cycle 10 of a DIV: stallreq=0 in that cycle, state IDLE next cycle, no ready pulse. A following MULHU of 0x10000×0x10000 returns 0x00000001.
- rst driven low asynchronously mid-DIV (between clock edges): ready, result and stallreq go 0 immediately. Back-to-back DIVU 100/7 then REMU 100/7 return 14 then 2, with one IDLE cycle between them.
